// File: rtl/l2_flush_sched_if.sv
// Flush-scheduler bus bundle.
// Groups the requester handshake, the L2 flush handshake, the CPU-request
// pass-through and the status outputs of l2_flush_sched.
//   slave  : the scheduler's view (requests and L2 responses in, grants/flush out)
//   master : the environment's view (the mirror image)
interface l2_flush_sched_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_data;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] req_done;
    logic             l2_flush_valid;
    logic             l2_flush_data;
    logic             l2_flush_ready;
    logic             flush_done;
    logic             cpu_req_valid_in;
    logic             cpu_req_ready_out;
    logic             l2_cpu_req_valid;
    logic             l2_cpu_req_ready;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  req_valid, req_data, l2_flush_ready, flush_done,
               cpu_req_valid_in, l2_cpu_req_ready,
        output req_ready, req_done, l2_flush_valid, l2_flush_data,
               cpu_req_ready_out, l2_cpu_req_valid, busy, timeout_err
    );

    modport master (
        output req_valid, req_data, l2_flush_ready, flush_done,
               cpu_req_valid_in, l2_cpu_req_ready,
        input  req_ready, req_done, l2_flush_valid, l2_flush_data,
               cpu_req_ready_out, l2_cpu_req_valid, busy, timeout_err
    );
endinterface

// File: rtl/l2_flush_sched.sv
// L2 flush scheduler.
// Arbitrates round-robin among N_REQ flush requesters, issues one flush at a
// time on the L2 flush valid/ready handshake, waits for the L2 flush_done
// pulse (with a saturating watchdog that raises a sticky timeout_err), then
// returns a one-cycle req_done pulse to the granted requester. While a flush
// is in flight (state != IDLE) the CPU request channel toward L2 is gated.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : l2_flush_sched_if.slave (requesters, L2 flush, CPU gate, status)
module l2_flush_sched #(
    parameter int N_REQ = 2,
    parameter int TO_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    l2_flush_sched_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(N_REQ - 1);
    localparam logic [TO_W-1:0]  WD_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  WD_MAX  = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] rr_reg;
    logic [IDX_W-1:0] grant_reg;
    logic             l2_flush_valid_reg;
    logic             l2_flush_data_reg;
    logic [N_REQ-1:0] req_done_reg;
    logic [TO_W-1:0]  wd_reg;
    logic             timeout_err_reg;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic             accept;
    logic             gate;

    // Round-robin pick: first valid index strictly after rr_reg, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && bus.req_valid[IDX_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

    // Acceptance is the only Mealy path; suppressed while rst is asserted
    // because the FSM ignores the request on that edge anyway.
    assign accept = (state_reg == ST_IDLE) && grant_found && !rst;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign bus.req_ready[gi] = accept && (grant_idx == IDX_W'(gi));
            assign bus.req_done[gi]  = req_done_reg[gi];
        end
    endgenerate

    assign gate                  = (state_reg != ST_IDLE);
    assign bus.l2_cpu_req_valid  = bus.cpu_req_valid_in & ~gate;
    assign bus.cpu_req_ready_out = bus.l2_cpu_req_ready & ~gate;
    assign bus.busy              = gate;
    assign bus.l2_flush_valid    = l2_flush_valid_reg;
    assign bus.l2_flush_data     = l2_flush_data_reg;
    assign bus.timeout_err       = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            rr_reg             <= RR_INIT;
            grant_reg          <= '0;
            l2_flush_valid_reg <= 1'b0;
            l2_flush_data_reg  <= 1'b0;
            req_done_reg       <= '0;
            wd_reg             <= '0;
            timeout_err_reg    <= 1'b0;
        end else begin
            req_done_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_reg          <= grant_idx;
                        rr_reg             <= grant_idx;
                        l2_flush_valid_reg <= 1'b1;
                        l2_flush_data_reg  <= bus.req_data[grant_idx];
                        state_reg          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // flush_done before the handshake is treated as spurious.
                    if (bus.l2_flush_ready) begin
                        l2_flush_valid_reg <= 1'b0;
                        l2_flush_data_reg  <= 1'b0;
                        if (bus.flush_done) begin
                            req_done_reg[grant_reg] <= 1'b1;
                            state_reg               <= ST_DONE;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.flush_done) begin
                        wd_reg                  <= '0;
                        req_done_reg[grant_reg] <= 1'b1;
                        state_reg               <= ST_DONE;
                    end else begin
                        if (wd_reg != WD_MAX) begin
                            wd_reg <= wd_reg + WD_ONE;
                        end
                        // Flag when the counter steps onto all-ones; the
                        // flush itself is never abandoned.
                        if (wd_reg == WD_MAX - WD_ONE) begin
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
